dmem_mmio_responder: RTL and testbench

- Responder for the processor's data-memory port. Receives address_dmem/data/wren and returns q_dmem.
- Low region passes through to the external data RAM. A small memory-mapped I/O window holds game peripherals: button capture, tick timer with compare interrupt, LED and score registers.
- Sits in the wrapper between the processor and the RAM/board I/O.

---
 rtl/dmem_mmio_responder_pkg.sv | 16 +
 rtl/dmem_mmio_responder_btn_edge_capture.sv | 46 ++++
 rtl/dmem_mmio_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets
// and the widths used by the address decode.
package dmem_mmio_responder_pkg;

   localparam int MMIO_OFF_W = 3;
   localparam logic [31:0] MMIO_REGS = 32'd7;

   localparam logic [MMIO_OFF_W-1:0] BTN_STAT  = 3'd0;
   localparam logic [MMIO_OFF_W-1:0] BTN_LVL   = 3'd1;
   localparam logic [MMIO_OFF_W-1:0] TIMER     = 3'd2;
   localparam logic [MMIO_OFF_W-1:0] TIMER_CMP = 3'd3;
   localparam logic [MMIO_OFF_W-1:0] IRQ       = 3'd4;
   localparam logic [MMIO_OFF_W-1:0] LED       = 3'd5;
   localparam logic [MMIO_OFF_W-1:0] SCORE     = 3'd6;

endpackage

// File: rtl/dmem_mmio_responder_btn_edge_capture.sv
// Button capture: two-flop synchronizer, rising-edge detect and sticky
// press flags with write-1-to-clear (a coincident edge wins over the clear).
module btn_edge_capture #(
   parameter int NUM_BTN = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btnIn,
   input  logic               clearEn,
   input  logic [NUM_BTN-1:0] clearMask,
   output logic [NUM_BTN-1:0] level,
   output logic [NUM_BTN-1:0] sticky
);

   logic [NUM_BTN-1:0] sync1Reg;
   logic [NUM_BTN-1:0] sync2Reg;
   logic [NUM_BTN-1:0] prevReg;
   logic [NUM_BTN-1:0] stickyReg;
   logic [NUM_BTN-1:0] stickyNext;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BTN; gi++) begin : gBit
         assign stickyNext[gi] = (sync2Reg[gi] & ~prevReg[gi])
                               | (stickyReg[gi] & ~(clearEn & clearMask[gi]));
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1Reg  <= '0;
         sync2Reg  <= '0;
         prevReg   <= '0;
         stickyReg <= '0;
      end else begin
         sync1Reg  <= btnIn;
         sync2Reg  <= sync1Reg;
         prevReg   <= sync2Reg;
         stickyReg <= stickyNext;
      end
   end

   assign level  = sync2Reg;
   assign sticky = stickyReg;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: RAM passthrough below 2^RAM_AW plus a small
// MMIO window with buttons, tick timer/compare interrupt, LEDs and score.
module dmem_mmio_responder
   import dmem_mmio_responder_pkg::*;
#(
   parameter int          RAM_AW    = 12,
   parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
   parameter int          PRESCALE  = 50000,
   parameter int          NUM_BTN   = 4,
   parameter int          LED_W     = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       address_dmem,
   input  logic [31:0]       data,
   input  logic              wren,
   output logic [31:0]       q_dmem,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   output logic              ram_we,
   input  logic [31:0]       ram_q,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [LED_W-1:0]  led,
   output logic [31:0]       score,
   output logic              timer_irq
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic                  inRam;
   logic                  inMmio;
   logic [31:0]           mmioOff;
   logic [MMIO_OFF_W-1:0] regOff;
   logic                  mmioWr;

   assign inRam   = (address_dmem >> RAM_AW) == 32'd0;
   assign mmioOff = address_dmem - MMIO_BASE;
   assign inMmio  = !inRam && (mmioOff < MMIO_REGS);
   assign regOff  = mmioOff[MMIO_OFF_W-1:0];
   assign mmioWr  = wren && inMmio;

   assign ram_addr  = address_dmem[RAM_AW-1:0];
   assign ram_wdata = data;
   assign ram_we    = wren && inRam;

   logic wrBtnStat, wrTimer, wrCmp, wrIrq, wrLed, wrScore;
   assign wrBtnStat = mmioWr && (regOff == BTN_STAT);
   assign wrTimer   = mmioWr && (regOff == TIMER);
   assign wrCmp     = mmioWr && (regOff == TIMER_CMP);
   assign wrIrq     = mmioWr && (regOff == IRQ);
   assign wrLed     = mmioWr && (regOff == LED);
   assign wrScore   = mmioWr && (regOff == SCORE);

   logic [NUM_BTN-1:0] btnLevel;
   logic [NUM_BTN-1:0] btnSticky;

   btn_edge_capture #(
      .NUM_BTN (NUM_BTN)
   ) uBtn (
      .clock     (clock),
      .reset     (reset),
      .btnIn     (btn_in),
      .clearEn   (wrBtnStat),
      .clearMask (data[NUM_BTN-1:0]),
      .level     (btnLevel),
      .sticky    (btnSticky)
   );

   logic [PS_W-1:0]  prescaleReg, prescaleNext;
   logic [31:0]      timerReg, timerNext;
   logic [31:0]      cmpReg, cmpNext;
   logic             irqReg, irqNext;
   logic [LED_W-1:0] ledReg, ledNext;
   logic [31:0]      scoreReg, scoreNext;
   logic             tick;

   assign tick = (prescaleReg == PS_LAST);

   // A processor write to TIMER beats a tick and never raises the compare flag.
   always_comb begin
      prescaleNext = prescaleReg + PS_W'(1);
      timerNext    = timerReg;
      cmpNext      = cmpReg;
      ledNext      = ledReg;
      scoreNext    = scoreReg;
      irqNext      = irqReg & ~(wrIrq & data[0]);
      if (tick) begin
         prescaleNext = '0;
      end
      if (wrTimer) begin
         prescaleNext = '0;
         timerNext    = data;
      end else if (tick) begin
         timerNext = timerReg + 32'd1;
         if ((timerReg + 32'd1) == cmpReg) begin
            irqNext = 1'b1;
         end
      end
      if (wrCmp) begin
         cmpNext = data;
      end
      if (wrLed) begin
         ledNext = data[LED_W-1:0];
      end
      if (wrScore) begin
         scoreNext = data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prescaleReg <= '0;
         timerReg    <= '0;
         cmpReg      <= '0;
         irqReg      <= 1'b0;
         ledReg      <= '0;
         scoreReg    <= '0;
      end else begin
         prescaleReg <= prescaleNext;
         timerReg    <= timerNext;
         cmpReg      <= cmpNext;
         irqReg      <= irqNext;
         ledReg      <= ledNext;
         scoreReg    <= scoreNext;
      end
   end

   always_comb begin
      q_dmem = '0;
      if (inRam) begin
         q_dmem = ram_q;
      end else if (inMmio) begin
         case (regOff)
            BTN_STAT:  q_dmem = 32'(btnSticky);
            BTN_LVL:   q_dmem = 32'(btnLevel);
            TIMER:     q_dmem = timerReg;
            TIMER_CMP: q_dmem = cmpReg;
            IRQ:       q_dmem = {31'd0, irqReg};
            LED:       q_dmem = 32'(ledReg);
            SCORE:     q_dmem = scoreReg;
            default:   q_dmem = '0;
         endcase
      end
   end

   assign led       = ledReg;
   assign score     = scoreReg;
   assign timer_irq = irqReg;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a 4-cycle timer prescaler.
module tb_dmem_mmio_responder;

   localparam logic [31:0] MB = 32'h0000_1000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address_dmem = '0;
   logic [31:0] data = '0;
   logic        wren = 1'b0;
   logic [31:0] q_dmem;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_we;
   logic [31:0] ram_q = 32'h1357_9BDF;
   logic [3:0]  btn_in = '0;
   logic [7:0]  led;
   logic [31:0] score;
   logic        timer_irq;

   int vecCount = 0;
   int missCount = 0;

   always #5 clock = ~clock;

   dmem_mmio_responder #(
      .RAM_AW    (12),
      .MMIO_BASE (MB),
      .PRESCALE  (4),
      .NUM_BTN   (4),
      .LED_W     (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_dmem       (q_dmem),
      .ram_addr     (ram_addr),
      .ram_wdata    (ram_wdata),
      .ram_we       (ram_we),
      .ram_q        (ram_q),
      .btn_in       (btn_in),
      .led          (led),
      .score        (score),
      .timer_irq    (timer_irq)
   );

   // Called one time unit after a rising edge; returns at the same phase.
   task automatic doWrite(input logic [31:0] a, input logic [31:0] d);
      address_dmem = a;
      data         = d;
      wren         = 1'b1;
      @(posedge clock);
      #1;
      wren = 1'b0;
      $display("wr addr=%h data=%h", a, d);
   endtask

   task automatic test_reset_release;
      address_dmem = MB + 32'd2;
      #1;
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL rst_timer: got %h want %h", q_dmem, 32'd0);
      end
      vecCount++;
      if ({led, score, timer_irq} !== 41'd0) begin
         missCount++; $display("FAIL rst_outs: got led=%h score=%h irq=%b want 0", led, score, timer_irq);
      end
   endtask

   task automatic test_timer;
      address_dmem = MB + 32'd2;
      repeat (4) @(posedge clock);
      #1;
      vecCount++;
      if (q_dmem !== 32'd1) begin
         missCount++; $display("FAIL timer_4clk: got %h want %h", q_dmem, 32'd1);
      end
      repeat (4) @(posedge clock);
      #1;
      vecCount++;
      if (q_dmem !== 32'd2) begin
         missCount++; $display("FAIL timer_8clk: got %h want %h", q_dmem, 32'd2);
      end
      doWrite(MB + 32'd2, 32'hFFFF_FFFF);
      vecCount++;
      if (q_dmem !== 32'hFFFF_FFFF) begin
         missCount++; $display("FAIL timer_load: got %h want %h", q_dmem, 32'hFFFF_FFFF);
      end
      repeat (3) @(posedge clock);
      #1;
      vecCount++;
      if (q_dmem !== 32'hFFFF_FFFF) begin
         missCount++; $display("FAIL timer_hold: got %h want %h", q_dmem, 32'hFFFF_FFFF);
      end
      @(posedge clock);
      #1;
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL timer_wrap: got %h want %h", q_dmem, 32'd0);
      end
      // TIMER_CMP is still 0, so the wrap to 0 is a compare hit.
      vecCount++;
      if (timer_irq !== 1'b1) begin
         missCount++; $display("FAIL irq_on_wrap: got %b want 1", timer_irq);
      end
   endtask

   task automatic test_compare;
      doWrite(MB + 32'd3, 32'd3);
      doWrite(MB + 32'd4, 32'd1);
      doWrite(MB + 32'd2, 32'd0);
      vecCount++;
      if (timer_irq !== 1'b0) begin
         missCount++; $display("FAIL irq_cleared: got %b want 0", timer_irq);
      end
      repeat (11) @(posedge clock);
      #1;
      vecCount++;
      if (timer_irq !== 1'b0 || q_dmem !== 32'd2) begin
         missCount++; $display("FAIL irq_early: got irq=%b timer=%h want irq=0 timer=2", timer_irq, q_dmem);
      end
      @(posedge clock);
      #1;
      vecCount++;
      if (timer_irq !== 1'b1 || q_dmem !== 32'd3) begin
         missCount++; $display("FAIL irq_set: got irq=%b timer=%h want irq=1 timer=3", timer_irq, q_dmem);
      end
      address_dmem = MB + 32'd4;
      #1;
      vecCount++;
      if (q_dmem !== 32'd1) begin
         missCount++; $display("FAIL irq_read: got %h want %h", q_dmem, 32'd1);
      end
      doWrite(MB + 32'd4, 32'd1);
      vecCount++;
      if (timer_irq !== 1'b0) begin
         missCount++; $display("FAIL irq_w1c: got %b want 0", timer_irq);
      end
      doWrite(MB + 32'd2, 32'd3);
      vecCount++;
      if (timer_irq !== 1'b0 || q_dmem !== 32'd3) begin
         missCount++; $display("FAIL irq_direct_wr: got irq=%b timer=%h want irq=0 timer=3", timer_irq, q_dmem);
      end
      repeat (4) @(posedge clock);
      #1;
      vecCount++;
      if (timer_irq !== 1'b0 || q_dmem !== 32'd4) begin
         missCount++; $display("FAIL irq_past: got irq=%b timer=%h want irq=0 timer=4", timer_irq, q_dmem);
      end
   endtask

   task automatic test_ram;
      address_dmem = 32'h0000_0005;
      data         = 32'hDEAD_BEEF;
      wren         = 1'b1;
      #1;
      vecCount++;
      if (ram_we !== 1'b1 || ram_addr !== 12'h005 || ram_wdata !== 32'hDEAD_BEEF) begin
         missCount++; $display("FAIL ram_wr: got we=%b addr=%h wdata=%h want 1/005/deadbeef", ram_we, ram_addr, ram_wdata);
      end
      vecCount++;
      if (q_dmem !== 32'h1357_9BDF) begin
         missCount++; $display("FAIL ram_rd: got %h want %h", q_dmem, 32'h1357_9BDF);
      end
      address_dmem = 32'h0000_1005;
      #1;
      vecCount++;
      if (ram_we !== 1'b0) begin
         missCount++; $display("FAIL ram_we_mmio: got %b want 0", ram_we);
      end
      address_dmem = 32'h0000_2000;
      wren         = 1'b0;
      #1;
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL unmapped_rd: got %h want %h", q_dmem, 32'd0);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_btn;
      address_dmem = MB;
      btn_in       = 4'b0100;
      @(posedge clock);
      #1;
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL btn_clk1: got %h want %h", q_dmem, 32'd0);
      end
      @(posedge clock);
      #1;
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL btn_clk2: got %h want %h", q_dmem, 32'd0);
      end
      @(posedge clock);
      #1;
      vecCount++;
      if (q_dmem !== 32'd4) begin
         missCount++; $display("FAIL btn_clk3: got %h want %h", q_dmem, 32'd4);
      end
      address_dmem = MB + 32'd1;
      #1;
      vecCount++;
      if (q_dmem !== 32'd4) begin
         missCount++; $display("FAIL btn_lvl: got %h want %h", q_dmem, 32'd4);
      end
      doWrite(MB, 32'd4);
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL btn_w1c: got %h want %h", q_dmem, 32'd0);
      end
      btn_in = 4'b0000;
      repeat (4) @(posedge clock);
      #1;
      btn_in = 4'b0100;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      address_dmem = MB;
      data         = 32'd4;
      wren         = 1'b1;
      @(posedge clock);
      #1;
      wren = 1'b0;
      vecCount++;
      if (q_dmem !== 32'd4) begin
         missCount++; $display("FAIL btn_set_wins: got %h want %h", q_dmem, 32'd4);
      end
   endtask

   task automatic test_led_score;
      doWrite(MB + 32'd5, 32'h0000_1234);
      vecCount++;
      if (led !== 8'h34 || q_dmem !== 32'h34) begin
         missCount++; $display("FAIL led: got led=%h q=%h want 34/00000034", led, q_dmem);
      end
      doWrite(MB + 32'd6, 32'd1000);
      vecCount++;
      if (score !== 32'd1000 || q_dmem !== 32'd1000) begin
         missCount++; $display("FAIL score: got score=%0d q=%0d want 1000", score, q_dmem);
      end
   endtask

   task automatic test_async_reset;
      doWrite(MB + 32'd2, 32'd7);
      doWrite(MB + 32'd5, 32'h0000_00FF);
      vecCount++;
      if (led !== 8'hFF) begin
         missCount++; $display("FAIL led_pre: got %h want ff", led);
      end
      address_dmem = MB + 32'd2;
      #2;
      reset = 1'b0;
      #1;
      vecCount++;
      if (led !== 8'h00 || score !== 32'd0 || timer_irq !== 1'b0) begin
         missCount++; $display("FAIL async_outs: got led=%h score=%h irq=%b want 0", led, score, timer_irq);
      end
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL async_timer: got %h want %h", q_dmem, 32'd0);
      end
      address_dmem = MB;
      #1;
      vecCount++;
      if (q_dmem !== 32'd0) begin
         missCount++; $display("FAIL async_btn: got %h want %h", q_dmem, 32'd0);
      end
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      test_reset_release;
      test_timer;
      test_compare;
      test_ram;
      test_btn;
      test_led_score;
      test_async_reset;
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
